// File: rtl/ppu_fb_writer.sv
// ---------------------------------------------------------------------------
// ppu_fb_writer
//   Sits downstream of the PPU pixel shifter. Each 2-bit colour index is mapped
//   through the BGP palette, four shades are packed per byte (first pixel in
//   [7:6]), and the bytes are written into a byte-addressed 160x144 framebuffer
//   (address = y*40 + x/4). A small FIFO of {addr,data} absorbs framebuffer
//   back-pressure. Line and frame position are tracked from PPU_MODE edges.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset (0 = reset)
//   LCD_EN      LCDC[7]; 0 = display off (flushes and idles the writer)
//   PPU_MODE    0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW
//   PX_IN       colour index from the PPU, qualified by PX_valid
//   PX_valid    PX_IN is valid this cycle
//   BGP         palette, shade(c) = BGP[2c+1:2c], sampled with the pixel
//   FB_WE       write request (FIFO non-empty)
//   FB_ADDR     byte address of the FIFO head, 0 while idle
//   FB_DATA     packed shades of the FIFO head, 0 while idle
//   FB_READY    framebuffer accepts the write when FB_WE && FB_READY
//   FRAME_DONE  one-cycle pulse once every byte of a frame has been written
//   OVERFLOW    sticky: a byte was dropped on a full FIFO
// ---------------------------------------------------------------------------
module ppu_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LINE_PX    = 160,
  parameter int LINES      = 144
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LCD_EN,
  input  logic [1:0]  PPU_MODE,
  input  logic [1:0]  PX_IN,
  input  logic        PX_valid,
  input  logic [7:0]  BGP,
  output logic        FB_WE,
  output logic [12:0] FB_ADDR,
  output logic [7:0]  FB_DATA,
  input  logic        FB_READY,
  output logic        FRAME_DONE,
  output logic        OVERFLOW
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0]     MODE_HBLANK = 2'd0;
  localparam logic [1:0]     MODE_VBLANK = 2'd1;
  localparam logic [1:0]     MODE_DRAW   = 2'd3;
  localparam logic [7:0]     LINE_PX_W   = 8'(LINE_PX);
  localparam logic [7:0]     LINES_W     = 8'(LINES);
  localparam logic [PTR_W:0] DEPTH_W     = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_WAIT_FRAME,
    ST_LINE,
    ST_LINE_END,
    ST_VBLANK
  } state_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [7:0]  data;
  } fb_wr_t;

  // Line/frame tracking state
  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [7:0] y_q, y_d;
  logic [7:0] pack_q, pack_d;
  logic [1:0] mode_q;
  logic       frame_done_q, frame_done_d;

  // FIFO state
  fb_wr_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;

  // Datapath helpers
  logic [2:0]  shade_lsb;
  logic [1:0]  shade;
  logic [12:0] line_base;
  logic [7:0]  flush_byte;
  logic        vblank_entry;
  logic        draw_end;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  fb_wr_t      push_wr;
  logic        push_ok;
  logic        pop;

  assign shade_lsb    = {PX_IN, 1'b0};
  assign shade        = BGP[shade_lsb +: 2];
  // y*40 as two shifts; 143*40 still fits in 13 bits.
  assign line_base    = ({5'd0, y_q} << 5) + ({5'd0, y_q} << 3);
  assign vblank_entry = (PPU_MODE == MODE_VBLANK) && (mode_q != MODE_VBLANK);
  assign draw_end     = (mode_q == MODE_DRAW) && (PPU_MODE == MODE_HBLANK);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_W);
  assign pop        = !fifo_empty && FB_READY;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok    = push && (!fifo_full || pop);

  // Partial byte at line end: the x[1:0] pixels already shifted in sit in the
  // low bits of pack_q; move them to the top and leave unused slots at 0.
  always_comb begin
    case (x_q[1:0])
      2'd1:    flush_byte = {pack_q[1:0], 6'd0};
      2'd2:    flush_byte = {pack_q[3:0], 4'd0};
      2'd3:    flush_byte = {pack_q[5:0], 2'd0};
      default: flush_byte = 8'd0;
    endcase
  end

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pack_d       = pack_q;
    frame_done_d = 1'b0;
    push         = 1'b0;
    push_wr      = '0;

    case (state_q)
      ST_WAIT_FRAME: begin
        if ((PPU_MODE == MODE_DRAW) && (y_q == 8'd0)) begin
          state_d = ST_LINE;
        end
      end

      ST_LINE: begin
        if (PX_valid && (x_q < LINE_PX_W)) begin
          pack_d = {pack_q[5:0], shade};
          x_d    = x_q + 8'd1;
          if (x_q[1:0] == 2'd3) begin
            push         = 1'b1;
            push_wr.addr = line_base + {7'd0, x_q[7:2]};
            push_wr.data = pack_d;
          end
        end
        // A V_BLANK entry mid-line is a short frame: flush as at a line end.
        if (vblank_entry || draw_end) begin
          state_d = ST_LINE_END;
        end
      end

      ST_LINE_END: begin
        if (x_q[1:0] != 2'd0) begin
          push         = 1'b1;
          push_wr.addr = line_base + {7'd0, x_q[7:2]};
          push_wr.data = flush_byte;
        end
        x_d = 8'd0;
        y_d = y_q + 8'd1;
        // PPU_MODE is still V_BLANK here when the flush was forced by it.
        if ((y_d == LINES_W) || (PPU_MODE == MODE_VBLANK)) begin
          state_d = ST_VBLANK;
        end else begin
          state_d = ST_LINE;
        end
      end

      ST_VBLANK: begin
        x_d = 8'd0;
        y_d = 8'd0;
        if (fifo_empty) begin
          frame_done_d = 1'b1;
          state_d      = ST_WAIT_FRAME;
        end
      end

      default: state_d = ST_WAIT_FRAME;
    endcase

    // Display off overrides everything and produces no frame-done pulse.
    if (!LCD_EN) begin
      state_d      = ST_WAIT_FRAME;
      x_d          = 8'd0;
      y_d          = 8'd0;
      pack_d       = 8'd0;
      push         = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_WAIT_FRAME;
      x_q          <= 8'd0;
      y_q          <= 8'd0;
      pack_q       <= 8'd0;
      mode_q       <= MODE_HBLANK;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pack_q       <= pack_d;
      mode_q       <= PPU_MODE;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (!LCD_EN) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
      count_q <= count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
    end
  end

  // NOTE: the FIFO storage has no reset; entries are only observable through
  // the occupancy count, which is reset, and outputs are gated while empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_wr;
    end
  end

  assign FB_WE      = !fifo_empty;
  assign FB_ADDR    = FB_WE ? mem_q[rd_ptr_q].addr : 13'd0;
  assign FB_DATA    = FB_WE ? mem_q[rd_ptr_q].data : 8'd0;
  assign FRAME_DONE = frame_done_q;
  assign OVERFLOW   = overflow_q;

endmodule
